// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Latency: MULT/MULTU busy for MULT_LAT cycles, DIV/DIVU for DIV_LAT; done pulses the cycle after.
// Backpressure: start is ignored while busy; MTHI/MTLO complete on the accepting edge.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   start, md_op   request strobe and opcode (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO)
//   a, b           operands (a also carries MTHI/MTLO data)
//   busy, done     in-flight flag and one-cycle completion pulse
//   hi, lo         architectural result registers
module md_unit #(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_done;

   logic             w_accept;
   logic             w_fin;
   logic             w_mt_hi;
   logic             w_mt_lo;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_fin       = 1'b0;
      w_mt_hi     = 1'b0;
      w_mt_lo     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               case (md_op)
                  3'd0, 3'd1, 3'd2, 3'd3: begin
                     w_accept    = 1'b1;
                     w_state_nxt = RUN;
                  end
                  3'd4:    w_mt_hi = 1'b1;
                  3'd5:    w_mt_lo = 1'b1;
                  default: ;
               endcase
            end
         end
         RUN: begin
            // Counter at 1 means this edge brings it to 0: retire now.
            if (r_cnt == CW'(1)) begin
               w_fin       = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Result computation from latched operands only
   // ------------------------------------------------------------------
   logic [2*WIDTH-1:0]      w_ax_s;
   logic [2*WIDTH-1:0]      w_bx_s;
   logic [2*WIDTH-1:0]      w_ax_u;
   logic [2*WIDTH-1:0]      w_bx_u;
   logic [2*WIDTH-1:0]      w_prod_s;
   logic [2*WIDTH-1:0]      w_prod_u;
   logic signed [WIDTH-1:0] w_sa;
   logic signed [WIDTH-1:0] w_sb;
   logic signed [WIDTH-1:0] w_qs;
   logic signed [WIDTH-1:0] w_rs;
   logic [WIDTH-1:0]        w_qu;
   logic [WIDTH-1:0]        w_ru;
   logic [WIDTH-1:0]        w_min_neg;
   logic                    w_b_zero;
   logic                    w_ovf;
   logic [2*WIDTH-1:0]      w_res;

   // The low 2*WIDTH bits of a product of sign-extended operands equal the
   // signed product, so one multiplier shape serves both modes.
   assign w_ax_s    = {{WIDTH{r_a[WIDTH-1]}}, r_a};
   assign w_bx_s    = {{WIDTH{r_b[WIDTH-1]}}, r_b};
   assign w_ax_u    = {{WIDTH{1'b0}}, r_a};
   assign w_bx_u    = {{WIDTH{1'b0}}, r_b};
   assign w_prod_s  = w_ax_s * w_bx_s;
   assign w_prod_u  = w_ax_u * w_bx_u;

   assign w_sa      = r_a;
   assign w_sb      = r_b;
   assign w_qs      = w_sa / w_sb;
   assign w_rs      = w_sa % w_sb;
   assign w_qu      = r_a / r_b;
   assign w_ru      = r_a % r_b;

   assign w_min_neg = {1'b1, {(WIDTH-1){1'b0}}};
   assign w_b_zero  = (r_b == '0);
   assign w_ovf     = (r_a == w_min_neg) && (r_b == '1);

   // w_res = {hi, lo}
   always_comb begin
      w_res = '0;
      case (r_op)
         2'd0: w_res = w_prod_s;
         2'd1: w_res = w_prod_u;
         2'd2: begin
            if (w_b_zero)   w_res = {r_a, {WIDTH{1'b1}}};
            else if (w_ovf) w_res = {{WIDTH{1'b0}}, r_a};
            else            w_res = {w_rs, w_qs};
         end
         default: begin
            if (w_b_zero) w_res = {r_a, {WIDTH{1'b1}}};
            else          w_res = {w_ru, w_qu};
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_op   <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_fin;
         if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= md_op[1:0];
            r_cnt <= md_op[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
         end else if (r_state == RUN) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_fin) begin
            r_hi <= w_res[2*WIDTH-1:WIDTH];
            r_lo <= w_res[WIDTH-1:0];
         end else if (w_mt_hi) begin
            r_hi <= a;
         end else if (w_mt_lo) begin
            r_lo <= a;
         end
      end
   end

   assign busy = (r_state == RUN);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO result registers.
- Next-generation companion to the single-cycle combinational ALU in the EX stage.
- Adds configurable width and latency, signed and unsigned modes, a busy/done handshake, and direct HI/LO writes.
- The pipeline stalls on busy for any later HI/LO access.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (≥ 2).
- MULT_LAT, 5, cycles busy stays high for MULT/MULTU (≥ 1).
- DIV_LAT, 10, cycles busy stays high for DIV/DIVU (≥ 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on the rising edge together with md_op, a and b.
- md_op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved (no-op).
- a  input  WIDTH  first operand (dividend / multiplicand / MTHI/MTLO data).
- b  input  WIDTH  second operand (divisor / multiplier).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when the HI/LO result becomes visible.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- **Reset:** rst_n low clears hi, lo, busy, done, the latched operands and the counter immediately, without waiting for a clock edge. This includes reset mid-operation; the in-flight result is discarded.
- **States:** IDLE and RUN. A down-counter holds the remaining cycles; busy = (state == RUN).
- **Accepting a request:** in IDLE, start=1 with md_op 0-3 latches a, b and md_op.
  - The counter loads MULT_LAT or DIV_LAT and the state goes to RUN.
  - busy is high for exactly LAT cycles, starting the cycle after the start edge.
- **RUN:** the counter decrements each edge. On the edge where the counter reaches 0:
  - hi/lo are written and the state returns to IDLE;
  - done = 1 for exactly that following cycle, with busy = 0 and the new hi/lo visible in the same cycle.
- **Start ignored:** start while busy is ignored, including MTHI/MTLO. Latched operands and the counter are unaffected.
- **MTHI/MTLO:** in IDLE, start with md_op 4 or 5 writes a into hi or lo on that edge. No busy, no done.
- **Reserved ops:** md_op 6-7 are ignored.
- **Back-to-back:** start is accepted again in the cycle done is high; that new operation's busy rises the next cycle.
- **MULT:** signed 2·WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits. **MULTU:** same, unsigned.
- **DIV:** signed; quotient truncates toward zero, remainder takes the sign of the dividend; lo = quotient, hi = remainder. **DIVU:** unsigned.
- **Divide by zero (DIV and DIVU):** lo = all ones, hi = a.
- **Signed overflow (DIV with a = most-negative value, b = −1):** lo = a, hi = 0.
- **Result computation:** may be combinational from the latched operands, written at completion. Operand inputs changing during RUN must not affect the result.
- **done:** registered, never high during reset, never high twice for one operation.

Test Plan:
- **Reset mid-RUN:** MULT a=7, b=6, assert rst_n low at RUN cycle 2 → hi=0, lo=0, busy=0 immediately; no done pulse ever appears afterward.
- **MULT signed:** MULT a=0xFFFF_FFFE (−2), b=3 → busy high 5 cycles, then done pulse with hi=0xFFFF_FFFF, lo=0xFFFF_FFFA. MULTU with the same operands → hi=0x0000_0002, lo=0xFFFF_FFFA.
- **DIV signed:** DIV a=−7 (0xFFFF_FFF9), b=2 → busy 10 cycles, then lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1). DIVU a=7, b=2 → lo=3, hi=1.
- **Corner divides:**
  - DIVU a=0x1234, b=0 → lo=0xFFFF_FFFF, hi=0x1234.
  - DIV a=0x8000_0000, b=0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- **Handshake:** start MULT, then assert start with MTHI a=0xAAAA during busy → ignored, and hi ends as the MULT result. A second start issued in the done cycle → accepted, with busy high the next cycle.
- **Direct writes:** in IDLE, MTLO a=0x55 → lo=0x55 next cycle, busy and done stay 0. md_op=7 with start → no register change. Rerun with WIDTH=8, MULT_LAT=1: MULT a=0x80, b=0x80 → hi=0x40, lo=0x00, busy high 1 cycle.
